// File: rtl/ip_pkg.sv
// Shared definitions for the IPv4 header inserter: FSM encoding, fixed header
// constants, the latched per-frame field bundle and the header word mux.
// Ports: none (package only).
package ip_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    HEADER = 2'd2,
    DATA   = 2'd3
  } ip_state_e;

  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [7:0]  IP_TOS        = 8'h00;
  localparam logic [15:0] IP_FLAGS_FRAG = 16'h4000;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam int          IP_HDR_BYTES  = 20;

  // Per-frame header fields, captured at SOF and held until the next frame.
  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] tot_len;
    logic [15:0] ident;
    logic [7:0]  ttl;
  } ip_fields_t;

  // 16-bit header word 'idx' (0..9). Word 5 is the checksum; pass 0 for it
  // when summing the header to compute the checksum.
  function automatic logic [15:0] hdr_word(input ip_fields_t f,
                                           input logic [15:0] chk,
                                           input logic [3:0]  idx);
    logic [15:0] w;
    w = '0;
    case (idx)
      4'd0:    w = {IP_VER_IHL, IP_TOS};
      4'd1:    w = f.tot_len;
      4'd2:    w = f.ident;
      4'd3:    w = IP_FLAGS_FRAG;
      4'd4:    w = {f.ttl, IP_PROTO_UDP};
      4'd5:    w = chk;
      4'd6:    w = f.src[31:16];
      4'd7:    w = f.src[15:0];
      4'd8:    w = f.dst[31:16];
      4'd9:    w = f.dst[15:0];
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ip_checksum.sv
// IPv4 header checksum: sum of ten header words, two end-around folds, invert.
// Latency: 3 cycles from start_i to done_o; csum_o holds until the next start.
// Backpressure: none; a start simply restarts the pipeline.
// Ports: clk_i, rst_i (sync, active-high), start_i, fields_i (frame fields),
//        csum_o (registered checksum), done_o (one-cycle pulse).
module ip_checksum
  import ip_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  ip_fields_t  fields_i,
  output logic [15:0] csum_o,
  output logic        done_o
);

  logic [19:0] sum_d;
  logic [19:0] sum_q;
  logic [16:0] fold1_q;
  logic [15:0] csum_q;
  logic        s1_q;
  logic        s2_q;
  logic        done_q;

  // Ten 16-bit words fit in 20 bits without overflow.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < IP_HDR_BYTES / 2; i++) begin
      sum_d = sum_d + {4'h0, hdr_word(fields_i, 16'h0000, 4'(i))};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q   <= '0;
      fold1_q <= '0;
      csum_q  <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      s1_q   <= start_i;
      s2_q   <= s1_q;
      done_q <= s2_q;
      if (start_i) sum_q <= sum_d;
      // First fold can itself carry out of bit 15, hence the second fold.
      if (s1_q) fold1_q <= {1'b0, sum_q[15:0]} + {13'h0, sum_q[19:16]};
      if (s2_q) csum_q  <= ~(fold1_q[15:0] + {15'h0, fold1_q[16]});
    end
  end

  assign csum_o = csum_q;
  assign done_o = done_q;

endmodule

// File: rtl/ip_datagram.sv
// Prepends a 20-byte IPv4 header to each UDP datagram on an 8-bit AXI-Stream.
// Latency: SOF seen -> header byte 0 after 4 cycles; payload then passes through combinationally.
// Backpressure: honours m_axis_tready in HEADER/DATA; upstream stalled during CALC/HEADER.
// Ports: s_axis_aclk, rst (sync, active-high); IP_* header fields; ip_enable
//        (0 = bypass); s_axis_* upstream bytes (tuser = SOF); m_axis_* IPv4 bytes.
module ip_datagram
  import ip_pkg::*;
(
  input  logic        s_axis_aclk,
  input  logic        rst,
  input  logic [31:0] IP_SrcAddr,
  input  logic [31:0] IP_DestAddr,
  input  logic [15:0] IP_TotLen,
  input  logic [15:0] IP_Ident,
  input  logic [7:0]  IP_TTL,
  input  logic        ip_enable,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
);

  ip_state_e   state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  ip_fields_t  fields_q, fields_d;
  logic        bypass_q, bypass_d;
  logic        calc_start;
  logic [15:0] csum;
  logic        csum_done;
  logic [15:0] hdr_w;
  logic        sof;

  assign sof   = s_axis_tvalid & s_axis_tuser;
  assign hdr_w = hdr_word(fields_q, csum, idx_q[4:1]);

  // Fed with the next-state fields so the sum starts on the SOF cycle itself;
  // done arrives in the third CALC cycle.
  ip_checksum u_csum (
    .clk_i    (s_axis_aclk),
    .rst_i    (rst),
    .start_i  (calc_start),
    .fields_i (fields_d),
    .csum_o   (csum),
    .done_o   (csum_done)
  );

  always_ff @(posedge s_axis_aclk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      fields_q <= '0;
      bypass_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      fields_q <= fields_d;
      bypass_q <= bypass_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    fields_d      = fields_q;
    bypass_d      = bypass_q;
    calc_start    = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tvalid = 1'b0;
    m_axis_tuser  = 1'b0;
    m_axis_tlast  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!ip_enable) begin
          // Bypass: wire straight through; only a multi-beat frame needs DATA.
          m_axis_tdata  = s_axis_tdata;
          m_axis_tvalid = s_axis_tvalid;
          m_axis_tuser  = s_axis_tuser;
          m_axis_tlast  = s_axis_tlast;
          s_axis_tready = m_axis_tready;
          if (sof && m_axis_tready && !s_axis_tlast) begin
            state_d  = DATA;
            bypass_d = 1'b1;
          end
        end else begin
          // Drop stray beats, but leave the SOF beat in place for DATA.
          s_axis_tready = ~s_axis_tuser;
          if (sof) begin
            state_d    = CALC;
            bypass_d   = 1'b0;
            calc_start = 1'b1;
            fields_d   = '{src: IP_SrcAddr, dst: IP_DestAddr, tot_len: IP_TotLen,
                           ident: IP_Ident, ttl: IP_TTL};
          end
        end
      end

      CALC: begin
        idx_d = '0;
        if (csum_done) state_d = HEADER;
      end

      HEADER: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = idx_q[0] ? hdr_w[7:0] : hdr_w[15:8];
        m_axis_tuser  = (idx_q == 5'd0);
        if (m_axis_tready) begin
          if (idx_q == 5'(IP_HDR_BYTES - 1)) begin
            idx_d   = '0;
            state_d = DATA;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end

      DATA: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast;
        // The upstream SOF marker now sits inside the packet; only bypass keeps it.
        m_axis_tuser  = bypass_q & s_axis_tuser;
        s_axis_tready = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ip_datagram.sv
module tb_ip_datagram;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IP_SrcAddr, IP_DestAddr;
  logic [15:0] IP_TotLen, IP_Ident;
  logic [7:0]  IP_TTL;
  logic        ip_enable;
  logic [7:0]  s_tdata;
  logic        s_tlast, s_tuser, s_tvalid, s_tready;
  logic [7:0]  m_tdata;
  logic        m_tlast, m_tuser, m_tvalid;
  logic        m_tready = 1'b1;

  always #5 clk = ~clk;

  ip_datagram dut (
    .s_axis_aclk   (clk),
    .rst           (rst),
    .IP_SrcAddr    (IP_SrcAddr),
    .IP_DestAddr   (IP_DestAddr),
    .IP_TotLen     (IP_TotLen),
    .IP_Ident      (IP_Ident),
    .IP_TTL        (IP_TTL),
    .ip_enable     (ip_enable),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Beats are {tuser, tlast, tdata}.
  logic [9:0] out_q[$];
  logic [9:0] exp_q[$];
  int         ocyc_q[$];
  bit         rnd_rdy = 1'b0;
  bit         byp_chk = 1'b0;
  bit         prev_stall = 1'b0;
  logic [9:0] prev_beat = '0;

  // Hand-computed headers for the three field sets used below.
  logic [7:0] hdr_a [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                             8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
  logic [7:0] hdr_b [20] = '{8'h45, 8'h00, 8'h00, 8'h1C, 8'h12, 8'h34, 8'h40, 8'h00, 8'h80, 8'h11,
                             8'hD4, 8'h9A, 8'h0A, 8'h00, 8'h00, 8'h01, 8'h0A, 8'h00, 8'h00, 8'h02};
  // Sum 0x6FFFC: first fold carries out, exercising the second fold.
  logic [7:0] hdr_c [20] = '{8'h45, 8'h00, 8'hFF, 8'hFF, 8'h7B, 8'hF0, 8'h40, 8'h00, 8'hFF, 8'h11,
                             8'hFF, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] cur_hdr [20];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Downstream sink.
  initial forever begin
    @(posedge clk); #1;
    m_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {21'h0, m_tvalid, m_tuser, m_tlast, m_tdata}, {21'h0, 1'b1, prev_beat});
      if (byp_chk) begin
        chk("byp_data", {24'h0, m_tdata}, {24'h0, s_tdata});
        chk("byp_ctrl", {28'h0, m_tvalid, m_tuser, m_tlast, s_tready},
                        {28'h0, s_tvalid, s_tuser, s_tlast, m_tready});
      end
      if (m_tvalid && m_tready) begin
        out_q.push_back({m_tuser, m_tlast, m_tdata});
        ocyc_q.push_back(cyc);
      end
      prev_stall = m_tvalid & ~m_tready;
      prev_beat  = {m_tuser, m_tlast, m_tdata};
    end
  end

  task automatic set_fields(input int sel);
    case (sel)
      0: begin
        IP_SrcAddr = 32'hC0A80001; IP_DestAddr = 32'hC0A800C7;
        IP_TotLen = 16'h0073; IP_Ident = 16'h0000; IP_TTL = 8'h40; cur_hdr = hdr_a;
      end
      1: begin
        IP_SrcAddr = 32'h0A000001; IP_DestAddr = 32'h0A000002;
        IP_TotLen = 16'h001C; IP_Ident = 16'h1234; IP_TTL = 8'h80; cur_hdr = hdr_b;
      end
      default: begin
        IP_SrcAddr = 32'hFFFFFFFF; IP_DestAddr = 32'hFFFFFFFF;
        IP_TotLen = 16'hFFFF; IP_Ident = 16'h7BF0; IP_TTL = 8'hFF; cur_hdr = hdr_c;
      end
    endcase
  endtask

  // Drive one upstream frame; ip_enable is inverted when beat flip_at is presented.
  task automatic send_frame(input int len, input logic [7:0] base, input int flip_at,
                            output int sof_cyc);
    sof_cyc = 0;
    for (int i = 0; i < len; i++) begin
      int w;
      bit hs;
      s_tvalid = 1'b1;
      s_tdata  = 8'(base + i);
      s_tuser  = (i == 0);
      s_tlast  = (i == len - 1);
      if (i == flip_at) ip_enable = ~ip_enable;
      if (i == 0) sof_cyc = cyc;
      w  = 0;
      hs = 1'b0;
      while (!hs && w < 200) begin
        @(negedge clk);
        hs = s_tready;
        @(posedge clk); #1;
        w++;
      end
      chk("src_handshake", {31'h0, hs}, 32'h1);
      if (!hs) break;
    end
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic exp_frame(input int len, input logic [7:0] base, input bit hdr);
    if (hdr) for (int i = 0; i < 20; i++) exp_q.push_back({(i == 0), 1'b0, cur_hdr[i]});
    for (int i = 0; i < len; i++)
      exp_q.push_back({(!hdr && i == 0), (i == len - 1), 8'(base + i)});
  endtask

  task automatic check_stream(input string tag);
    int n;
    chk({tag, "_count"}, out_q.size(), exp_q.size());
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(tag, {22'h0, out_q[i]}, {22'h0, exp_q[i]});
    out_q.delete();
    exp_q.delete();
    ocyc_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int sofa, sofb, d, w;
    rst = 1'b1; ip_enable = 1'b1;
    s_tdata = 8'h00; s_tlast = 1'b0; s_tuser = 1'b0; s_tvalid = 1'b0;
    set_fields(0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_tvalid", {31'h0, m_tvalid}, 32'h0);
    chk("rst_tuser",  {31'h0, m_tuser},  32'h0);
    chk("rst_tlast",  {31'h0, m_tlast},  32'h0);
    chk("rst_tdata",  {24'h0, m_tdata},  32'h0);
    @(posedge clk); #1;

    // Garbage beats before SOF are absorbed.
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1; s_tuser = 1'b0; s_tdata = 8'(8'hE0 + i);
      @(negedge clk);
      chk("idle_tready", {31'h0, s_tready}, 32'h1);
      chk("idle_tvalid", {31'h0, m_tvalid}, 32'h0);
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    chk("garbage_out", out_q.size(), 0);

    // 8-byte frame then a back-to-back single-beat frame, ready always high.
    send_frame(8, 8'h10, -1, sofa);
    send_frame(1, 8'h80, -1, sofb);
    if (ocyc_q.size() >= 49) begin
      chk("sof_to_hdr_latency", ocyc_q[0] - sofa, 4);
      chk("a_tlast_beat28", {31'h0, out_q[27][8]}, 32'h1);
      chk("b2b_sof_gap", sofb - ocyc_q[27], 1);
      // SOF of B is seen the cycle after A's tlast, then 4 cycles to header.
      chk("b2b_hdr_gap", ocyc_q[28] - ocyc_q[27], 5);
    end else begin
      chk("ab_beats", ocyc_q.size(), 49);
    end
    exp_frame(8, 8'h10, 1'b1);
    exp_frame(1, 8'h80, 1'b1);
    check_stream("frames_ab");

    // Fields change mid-frame must not affect the latched header.
    set_fields(1);
    fork
      send_frame(4, 8'hA0, -1, d);
      begin
        repeat (6) @(posedge clk);
        #1;
        IP_SrcAddr = 32'hDEADBEEF; IP_TTL = 8'h01; IP_TotLen = 16'h5555;
      end
    join
    exp_frame(4, 8'hA0, 1'b1);
    set_fields(2);
    send_frame(3, 8'hC0, -1, d);
    exp_frame(3, 8'hC0, 1'b1);
    check_stream("csum_latch");

    // 100 frames with random downstream stalls.
    set_fields(0);
    rnd_rdy = 1'b1;
    for (int f = 0; f < 100; f++) begin
      send_frame(1 + (f % 8), 8'(f * 3), -1, d);
      exp_frame(1 + (f % 8), 8'(f * 3), 1'b1);
    end
    check_stream("random_ready");

    // Bypass: output tracks input cycle for cycle.
    ip_enable = 1'b0;
    byp_chk   = 1'b1;
    send_frame(5, 8'h50, -1, d);
    send_frame(3, 8'h60, -1, d);
    byp_chk   = 1'b0;
    exp_frame(5, 8'h50, 1'b0);
    exp_frame(3, 8'h60, 1'b0);
    check_stream("bypass");

    // Mode changes mid-frame take effect only at the next frame.
    ip_enable = 1'b1;
    send_frame(6, 8'h70, 2, d);
    byp_chk = 1'b1;
    send_frame(4, 8'h90, 1, d);
    byp_chk = 1'b0;
    send_frame(2, 8'hB0, -1, d);
    exp_frame(6, 8'h70, 1'b1);
    exp_frame(4, 8'h90, 1'b0);
    exp_frame(2, 8'hB0, 1'b1);
    check_stream("toggle");

    // Reset while header byte 7 is on the bus, then a clean packet.
    rnd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fork
      send_frame(5, 8'h40, -1, d);
      begin
        w = 0;
        while (out_q.size() < 8 && w < 100) begin
          @(negedge clk); #1;
          w++;
        end
        chk("rst_at_byte7", out_q.size(), 8);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rst_abort_tvalid", {31'h0, m_tvalid}, 32'h0);
        rst = 1'b0;
        out_q.delete();
        ocyc_q.delete();
      end
    join
    exp_frame(5, 8'h40, 1'b1);
    check_stream("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
